// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory request/response path.
package imem_pkg;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_ADDR_W = 32;
    localparam logic [IMEM_DATA_W-1:0] RISCV_NOP = 32'h00000013;

    typedef struct packed {
        logic [IMEM_DATA_W-1:0] data;
        logic                   err;
    } imem_resp_t;

    // In-flight queue entry; age counts down to 0 when the response may present.
    typedef struct packed {
        logic [IMEM_DATA_W-1:0] data;
        logic                   err;
        logic [3:0]             age;
    } imem_entry_t;
endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response bundle between cpu_top (master) and the instruction store (slave).
interface imem_responder_if;
    logic                              imem_req_valid;
    logic [imem_pkg::IMEM_ADDR_W-1:0]  imem_req_addr;
    logic                              imem_req_ready;
    logic                              imem_resp_valid;
    logic [imem_pkg::IMEM_DATA_W-1:0]  imem_resp_data;
    logic                              imem_resp_err;
    logic                              imem_resp_ready;

    modport master (
        output imem_req_valid, imem_req_addr, imem_resp_ready,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_resp_ready,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
    );
endinterface

// File: rtl/imem_req_fifo.sv
// In-order queue of pending fetch responses; every entry's age counts down to 0 each cycle.
module imem_req_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  imem_entry_t push_entry,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output imem_entry_t head
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_MSB = PW'(1) << (PW - 1);

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [IW-1:0]   wr_idx, rd_idx;
    imem_entry_t     ent [DEPTH];

    generate
        if (DEPTH > 1) begin : g_idx
            assign wr_idx = wr_ptr[IW-1:0];
            assign rd_idx = rd_ptr[IW-1:0];
        end else begin : g_idx1
            assign wr_idx = '0;
            assign rd_idx = '0;
        end
    endgenerate

    assign full  = (wr_ptr ^ rd_ptr) == PTR_MSB;
    assign empty = wr_ptr == rd_ptr;
    assign head  = ent[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
        end
    end

    // Stale slots also age down; saturation keeps that harmless and a push overwrites them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset_n)
                ent[i] <= '0;
            else if (push && wr_idx == IW'(i))
                ent[i] <= push_entry;
            else if (ent[i].age != 4'd0)
                ent[i].age <= ent[i].age - 4'd1;
        end
    end
endmodule

// File: rtl/imem_responder.sv
// Instruction store behind cpu_top's fetch port: preloadable RAM, fixed-latency in-order responses.
module imem_responder
    import imem_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    imem_responder_if.slave              bus,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [IMEM_DATA_W-1:0]       init_data
);
    localparam int WIDX = $clog2(MEM_WORDS);

    logic [IMEM_DATA_W-1:0] mem [MEM_WORDS];
    logic [29:0]            word;
    logic                   req_err;
    logic                   req_fire;
    logic                   resp_fire;
    logic                   full, empty;
    imem_entry_t            push_entry, head;
    imem_resp_t             resp;

    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= init_data;
    end

    assign word    = bus.imem_req_addr[31:2];
    assign req_err = (bus.imem_req_addr[1:0] != 2'b00) || (word >= 30'(MEM_WORDS));

    // Asynchronous read in the accept cycle, so a same-cycle preload write is not seen.
    always_comb begin
        push_entry      = '0;
        push_entry.err  = req_err;
        push_entry.age  = 4'(LATENCY - 1);
        if (!req_err)
            push_entry.data = mem[bus.imem_req_addr[WIDX+1:2]];
    end

    assign bus.imem_req_ready = !full;
    assign req_fire  = bus.imem_req_valid && !full;
    assign resp_fire = bus.imem_resp_valid && bus.imem_resp_ready;

    imem_req_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (req_fire),
        .push_entry (push_entry),
        .pop        (resp_fire),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    assign bus.imem_resp_valid = !empty && (head.age == 4'd0);
    assign resp = bus.imem_resp_valid ? imem_resp_t'{data: head.data, err: head.err} : '0;
    assign bus.imem_resp_data  = resp.data;
    assign bus.imem_resp_err   = resp.err;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: scoreboard of expected responses checked by a negedge monitor.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int MEM_WORDS   = 1024;
    localparam int LATENCY     = 2;
    localparam int OUTSTANDING = 4;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_data;

    imem_responder_if bus();

    imem_responder #(
        .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .OUTSTANDING(OUTSTANDING)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_cnt = 0;
    exp_t        sb[$];
    logic [31:0] mdl [MEM_WORDS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every response handshake, checks stall stability and idle zeroing.
    initial begin
        logic        stall_vld;
        logic [32:0] stall_val;
        exp_t        e;
        stall_vld = 1'b0;
        stall_val = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_vld = 1'b0;
            end else begin
                if (!bus.imem_resp_valid)
                    chk("idle_zero", {31'b0, bus.imem_resp_err, bus.imem_resp_data}, 64'd0);
                if (stall_vld)
                    chk("stall_stable", {30'b0, bus.imem_resp_valid, bus.imem_resp_err, bus.imem_resp_data},
                        {30'b0, 1'b1, stall_val});
                if (bus.imem_resp_valid && bus.imem_resp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL unexpected_resp: got data %0h with empty scoreboard, expected none",
                               bus.imem_resp_data);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_data", 64'(bus.imem_resp_data), 64'(e.d));
                        chk("resp_err", 64'(bus.imem_resp_err), 64'(e.e));
                        chk("resp_latency", 64'((cyc - e.t) >= LATENCY), 64'd1);
                    end
                    resp_cnt++;
                end
                stall_vld = bus.imem_resp_valid && !bus.imem_resp_ready;
                stall_val = {bus.imem_resp_err, bus.imem_resp_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic init_wr(input int idx, input logic [31:0] d);
        init_we   = 1'b1;
        init_addr = 10'(idx);
        init_data = d;
        @(posedge clk);
        #1;
        init_we   = 1'b0;
        mdl[idx]  = d;
    endtask

    function automatic exp_t expect_for(input logic [31:0] a);
        exp_t e;
        e.e = (a[1:0] != 2'b00) || (a[31:2] >= 30'(MEM_WORDS));
        e.d = e.e ? 32'd0 : mdl[a[11:2]];
        e.t = cyc;
        return e;
    endfunction

    // Presents one request and holds it until accepted; push happens in the accept cycle.
    task automatic send(input logic [31:0] a);
        int n;
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = a;
        n = 0;
        @(negedge clk);
        while (!bus.imem_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req_ready) begin
            checks++;
            errors++;
            $error("FAIL req_timeout: req_ready 0 after 200 cycles, expected 1");
        end else begin
            sb.push_back(expect_for(a));
        end
        @(posedge clk);
        #1;
        bus.imem_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int acc;
        exp_t e;

        reset_n = 1'b0;
        init_we = 1'b0;
        init_addr = '0;
        init_data = '0;
        bus.imem_req_valid  = 1'b0;
        bus.imem_req_addr   = '0;
        bus.imem_resp_ready = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) mdl[i] = 32'hx;

        // Preload while in reset; RAM writes are legal then.
        @(posedge clk);
        #1;
        init_wr(0, 32'h00100093);
        init_wr(1, 32'h00200113);
        init_wr(2, 32'h002081B3);
        init_wr(3, 32'h40208233);
        for (int i = 4; i < 8; i++) init_wr(i, 32'h1111_0000 + 32'(i));
        init_wr(1023, 32'hCAFE_03FF);
        reset_n = 1'b1;

        @(negedge clk);
        chk("rst_req_ready", 64'(bus.imem_req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.imem_resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.imem_resp_data), 64'd0);
        chk("rst_resp_err", 64'(bus.imem_resp_err), 64'd0);
        @(posedge clk);
        #1;

        // In-order responses with the requester always ready.
        send(32'h0);
        send(32'h4);
        send(32'h8);
        send(32'hC);
        drain();

        // Back-pressure: four fill the queue, the fifth waits for a pop.
        bus.imem_resp_ready = 1'b0;
        send(32'h0);
        send(32'h4);
        send(32'h8);
        send(32'hC);
        @(negedge clk);
        chk("full_ready", 64'(bus.imem_req_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("full_hold_ready", 64'(bus.imem_req_ready), 64'd0);
        end
        base = resp_cnt;
        @(posedge clk);
        #1;
        bus.imem_resp_ready = 1'b1;
        send(32'h10);
        chk("fifth_after_pop", 64'(resp_cnt > base), 64'd1);
        drain();
        chk("bp_resp_total", 64'(resp_cnt - base), 64'd5);

        // Misaligned, out-of-range and last-word requests.
        send(32'h6);
        send(32'h1000);
        send(32'hFFC);
        drain();

        // Same-cycle preload write stays invisible; the next-cycle repeat sees it.
        init_we   = 1'b1;
        init_addr = 10'd5;
        init_data = 32'hDEADBEEF;
        bus.imem_req_valid = 1'b1;
        bus.imem_req_addr  = 32'h14;
        @(negedge clk);
        chk("coll_ready", 64'(bus.imem_req_ready), 64'd1);
        sb.push_back(expect_for(32'h14));
        @(posedge clk);
        #1;
        init_we = 1'b0;
        mdl[5]  = 32'hDEADBEEF;
        @(negedge clk);
        sb.push_back(expect_for(32'h14));
        @(posedge clk);
        #1;
        bus.imem_req_valid = 1'b0;
        drain();

        // Reset with two requests in flight; nothing stale may emerge afterwards.
        bus.imem_resp_ready = 1'b0;
        send(32'h0);
        send(32'h4);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("post_rst_valid", 64'(bus.imem_resp_valid), 64'd0);
        chk("post_rst_ready", 64'(bus.imem_req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.imem_resp_ready = 1'b1;
        base = resp_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 64'(resp_cnt - base), 64'd0);

        // Streaming: one request per cycle, responses must keep pace and wrap the pointers.
        base = resp_cnt;
        acc  = 0;
        bus.imem_req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.imem_req_addr = 32'((acc % 8) * 4);
            @(negedge clk);
            if (bus.imem_req_ready) begin
                e = expect_for(bus.imem_req_addr);
                sb.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.imem_req_valid = 1'b0;
        chk("stream_accepts", 64'(acc), 64'd100);
        chk("stream_rate", 64'(resp_cnt - base), 64'd98);
        drain();
        chk("stream_total", 64'(resp_cnt - base), 64'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
